// File: rtl/aexm_ifetch.sv
// aexm_ifetch: instruction fetch/prefetch unit.
// Keeps the fetch PC and issues one word read at a time over a req/ack
// handshake. Returned words are queued in a small FIFO whose head, with its
// PC, feeds the decode stage. A branch flushes the FIFO and restarts fetch.
// Optional bus-error handling is enabled by defining AEXM_IFETCH_BUSERR_EN.
module aexm_ifetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        d_en,
  input  logic        br_en,
  input  logic [31:0] br_adr,
  output logic        if_req,
  output logic [31:0] if_adr,
  input  logic        if_ack,
  input  logic [31:0] if_dat,
`ifdef AEXM_IFETCH_BUSERR_EN
  input  logic        if_err,
`endif
  output logic [31:0] aexm_icache_datai,
  output logic        ins_vld,
  output logic [31:0] rPC,
  output logic        fBUSY
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] NOP_WORD = 32'h88000000;
  localparam logic [31:0] ERR_WORD = 32'hBA2D0008;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DISCARD = 2'd2} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg;
  logic [31:0]   if_adr_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];

  logic [31:0]   br_pc;
  logic [31:0]   push_data;
  logic          push, pop, issue, fault, halted, has_space;
  logic          unused_br;

  // Word-aligned redirect target; the low address bits carry no meaning.
  assign br_pc     = {br_adr[31:2], 2'b00};
  assign unused_br = ^br_adr[1:0];
  // count only reaches DEPTH (a power of two) when full, so its MSB is "full".
  assign has_space = ~count_reg[AW];

`ifdef AEXM_IFETCH_BUSERR_EN
  logic halted_reg;

  assign fault  = if_err;
  assign halted = halted_reg;

  // A faulting fetch parks the unit until the next redirect.
  always_ff @(posedge gclk) begin
    if (!grst) begin
      halted_reg <= 1'b0;
    end else if (br_en) begin
      halted_reg <= 1'b0;
    end else if (push && fault) begin
      halted_reg <= 1'b1;
    end
  end
`else
  assign fault  = 1'b0;
  assign halted = 1'b0;
`endif

  // State register.
  always_ff @(posedge gclk) begin
    if (!grst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: one request in flight; a redirect mid-request waits out the ack.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!br_en && !halted && has_space) state_next = REQ;
      REQ:     if (if_ack) state_next = IDLE;
               else if (br_en) state_next = DISCARD;
      DISCARD: if (if_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs and datapath strobes; a redirect overrides both push and pop.
  always_comb begin
    if_req            = (state_reg == REQ) || (state_reg == DISCARD);
    fBUSY             = if_req;
    if_adr            = if_adr_reg;
    ins_vld           = (count_reg != '0);
    aexm_icache_datai = ins_vld ? mem_data[rd_ptr_reg] : NOP_WORD;
    rPC               = ins_vld ? mem_pc[rd_ptr_reg] : fetch_pc_reg;
    push              = (state_reg == REQ) && if_ack && !br_en;
    pop               = d_en && ins_vld && !br_en;
    issue             = (state_reg == IDLE) && (state_next == REQ);
    push_data         = fault ? ERR_WORD : if_dat;
  end

  // Fetch PC and the latched request address.
  always_ff @(posedge gclk) begin
    if (!grst) begin
      fetch_pc_reg <= RESET_PC;
      if_adr_reg   <= RESET_PC;
    end else begin
      if (br_en) begin
        fetch_pc_reg <= br_pc;
      end else if (push && !fault) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      if (issue) begin
        if_adr_reg <= fetch_pc_reg;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge gclk) begin
    if (!grst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (br_en) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage: returned word and the address it was fetched from.
  always_ff @(posedge gclk) begin
    if (push) begin
      mem_data[wr_ptr_reg] <= push_data;
      mem_pc[wr_ptr_reg]   <= if_adr_reg;
    end
  end
endmodule

// File: tb/tb_aexm_ifetch.sv
// Self-checking bench for aexm_ifetch: behavioural memory, scoreboard queue
// of expected FIFO entries, directed redirect/flush/reset scenarios.
// Define AEXM_IFETCH_BUSERR_EN to also exercise bus-error handling.
module tb_aexm_ifetch;
  localparam logic [31:0] K   = 32'hA5A5A5A5;
  localparam logic [31:0] NOP = 32'h88000000;
  localparam logic [31:0] ERR = 32'hBA2D0008;

  logic        gclk = 1'b0;
  logic        grst = 1'b0;
  logic        d_en = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_adr = '0;
  logic        if_ack = 1'b0;
  logic [31:0] if_dat = '0;
  logic        if_req, ins_vld, fBUSY;
  logic [31:0] if_adr, aexm_icache_datai, rPC;
`ifdef AEXM_IFETCH_BUSERR_EN
  logic        if_err = 1'b0;
`endif

  always #5 gclk = ~gclk;

  aexm_ifetch #(.DEPTH(4), .RESET_PC(32'h00000000)) dut (
    .gclk(gclk),
    .grst(grst),
    .d_en(d_en),
    .br_en(br_en),
    .br_adr(br_adr),
    .if_req(if_req),
    .if_adr(if_adr),
    .if_ack(if_ack),
    .if_dat(if_dat),
`ifdef AEXM_IFETCH_BUSERR_EN
    .if_err(if_err),
`endif
    .aexm_icache_datai(aexm_icache_datai),
    .ins_vld(ins_vld),
    .rPC(rPC),
    .fBUSY(fBUSY)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] pc;
  } entry_t;

  entry_t      sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] err_adr = 32'hFFFFFFFF;
  int          mem_lat = 1;
  int          wait_cnt = 0;
  int          ack_cnt = 0;
  logic        killed = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: compare head against the scoreboard, run the memory, update model.
  task automatic tick();
    logic   err;
    entry_t e;
    err = 1'b0;
    if (!grst) begin
      if_ack   = 1'b0;
      wait_cnt = 0;
      killed   = 1'b0;
      sb.delete();
      exp_pc   = 32'h0;
    end else begin
      check("ins_vld", ins_vld, 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("head_dat", aexm_icache_datai, sb[0].dat);
        check("head_pc", rPC, sb[0].pc);
      end else begin
        check("empty_dat", aexm_icache_datai, NOP);
        check("empty_pc", rPC, exp_pc);
      end
      if (if_req) begin
        if (wait_cnt >= mem_lat) begin
          if_ack   = 1'b1;
          if_dat   = if_adr ^ K;
          err      = (if_adr == err_adr);
          wait_cnt = 0;
        end else begin
          if_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        if_ack   = 1'b0;
        wait_cnt = 0;
      end
      if (d_en && !br_en && sb.size() != 0) begin
        e = sb.pop_front();
        $display("pop  pc=%h dat=%h", e.pc, e.dat);
      end
      if (if_ack) begin
        ack_cnt++;
        if (!killed && !br_en) begin
          check("ack_adr", if_adr, exp_pc);
          if (err) begin
            sb.push_back({ERR, exp_pc});
          end else begin
            sb.push_back({exp_pc ^ K, exp_pc});
            exp_pc = exp_pc + 32'd4;
          end
          $display("ack  adr=%h err=%0d", if_adr, err);
        end else begin
          $display("ack  adr=%h dropped", if_adr);
        end
        killed = 1'b0;
      end else if (br_en && if_req) begin
        killed = 1'b1;
      end
      if (br_en) begin
        sb.delete();
        exp_pc = {br_adr[31:2], 2'b00};
        $display("br   adr=%h", br_adr);
      end
    end
`ifdef AEXM_IFETCH_BUSERR_EN
    if_err = err;
`endif
    @(posedge gclk);
    @(negedge gclk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic branch(input logic [31:0] adr);
    br_adr = adr;
    br_en  = 1'b1;
    tick();
    br_en  = 1'b0;
  endtask

  task automatic pop1();
    d_en = 1'b1;
    tick();
    d_en = 1'b0;
  endtask

  // Advance until a request to adr is visible, bounded.
  task automatic wait_req(input string tag, input logic [31:0] adr);
    int n;
    n = 0;
    while (!(if_req && if_adr == adr) && n < 60) begin
      tick();
      n++;
    end
    check(tag, if_adr, adr);
    check({tag, "_req"}, 32'(if_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge gclk);
    tick();
    tick();
    // Reset values, sampled while reset is still applied.
    check("rst_req", 32'(if_req), 32'd0);
    check("rst_adr", if_adr, 32'h0);
    check("rst_vld", 32'(ins_vld), 32'd0);
    check("rst_dat", aexm_icache_datai, NOP);
    check("rst_pc", rPC, 32'h0);
    check("rst_busy", 32'(fBUSY), 32'd0);
    grst = 1'b1;

    // 1: fill to four words, then fetch stops.
    ack_cnt = 0;
    run(20);
    check("t1_acks", 32'(ack_cnt), 32'd4);
    check("t1_idle", 32'(if_req), 32'd0);
    check("t1_head", aexm_icache_datai, 32'hA5A5A5A5);
    check("t1_rpc", rPC, 32'h0);

    // 2: one pop frees exactly one slot.
    pop1();
    check("t2_head", aexm_icache_datai, 32'hA5A5A5A1);
    check("t2_rpc", rPC, 32'h4);
    ack_cnt = 0;
    run(10);
    check("t2_acks", 32'(ack_cnt), 32'd1);
    check("t2_adr", if_adr, 32'h10);
    check("t2_idle", 32'(if_req), 32'd0);

    // 3: redirect while idle with three words queued.
    pop1();
    branch(32'h00000103);
    check("t3_vld", 32'(ins_vld), 32'd0);
    check("t3_rpc", rPC, 32'h100);
    wait_req("t3_adr", 32'h100);

    // 4: redirect while the request to 0x8 is outstanding.
    branch(32'h0);
    wait_req("t4_adr8", 32'h8);
    mem_lat = 3;
    branch(32'h200);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_req", 32'(if_req), 32'd1);
      check("t4_hold_adr", if_adr, 32'h8);
      check("t4_busy", 32'(fBUSY), 32'd1);
      tick();
    end
    check("t4_released", 32'(if_req), 32'd0);
    mem_lat = 1;
    wait_req("t4_adr", 32'h200);
    run(20);
    check("t4_head", aexm_icache_datai, 32'hA5A5A7A5);
    check("t4_rpc", rPC, 32'h200);

    // 5: redirect coinciding with an ack, then push and pop together.
    branch(32'h300);
    wait_req("t5_adr300", 32'h300);
    tick();
    branch(32'h40);
    check("t5_no_discard", 32'(if_req), 32'd0);
    wait_req("t5_adr", 32'h40);
    wait_req("t5_adr48", 32'h48);
    tick();
    pop1();
    check("t5_order", aexm_icache_datai, 32'hA5A5A5E1);
    check("t5_rpc", rPC, 32'h44);
    ack_cnt = 0;
    run(20);
    check("t5_refill", 32'(ack_cnt), 32'd2);
    for (int i = 0; i < 4; i++) pop1();

`ifdef AEXM_IFETCH_BUSERR_EN
    // 6: bus error at 0x8 halts fetch until the next redirect.
    err_adr = 32'h8;
    branch(32'h0);
    ack_cnt = 0;
    run(25);
    check("t6_acks", 32'(ack_cnt), 32'd3);
    check("t6_halt", 32'(if_req), 32'd0);
    pop1();
    pop1();
    check("t6_head", aexm_icache_datai, ERR);
    check("t6_rpc", rPC, 32'h8);
    err_adr = 32'hFFFFFFFF;
    branch(32'h500);
    wait_req("t6_resume", 32'h500);
`endif

    // 7: reset in the middle of a request abandons it.
    mem_lat = 10;
    branch(32'h600);
    wait_req("t7_adr", 32'h600);
    tick();
    grst = 1'b0;
    tick();
    check("t7_req", 32'(if_req), 32'd0);
    check("t7_busy", 32'(fBUSY), 32'd0);
    check("t7_vld", 32'(ins_vld), 32'd0);
    check("t7_rpc", rPC, 32'h0);
    check("t7_adr", if_adr, 32'h0);
    grst = 1'b1;
    mem_lat = 1;
    wait_req("t7_restart", 32'h0);
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aexm_ifetch.md
Name: aexm_ifetch

Overview:
- Instruction fetch/prefetch unit. It is the producer side of the instruction word consumed by the instruction buffer/decode stage.
- Maintains the fetch PC and issues single-word reads to instruction memory/icache over a req/ack handshake.
- Buffers returned words in a small FIFO and presents the head word (plus its PC) on aexm_icache_datai.
- Branch redirects flush the buffer and restart fetch at the target.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, minimum 2
RESET_PC, 32'h00000000, fetch address after reset; bits [1:0] must be 0

Ports:
gclk  in  1  clock; all state on rising edge
grst  in  1  synchronous active-low reset; 0 = reset
d_en  in  1  decode advance; pops head word when ins_vld=1
br_en  in  1  branch/redirect strobe, single cycle
br_adr  in  32  redirect target; bits [1:0] ignored
if_req  out  1  memory read request
if_adr  out  32  memory word address, bits [1:0]=0
if_ack  in  1  read data valid / request complete
if_dat  in  32  read data
aexm_icache_datai  out  32  head instruction word, or NOP 32'h88000000 when empty
ins_vld  out  1  head word valid
rPC  out  32  PC of head word; PC of next fetch when empty
fBUSY  out  1  request outstanding

Behaviour:
- Reset (grst=0 at a clock edge):
  - FIFO emptied, count=0.
  - fetch_pc=RESET_PC; state=IDLE.
  - if_req=0, if_adr=RESET_PC, ins_vld=0, aexm_icache_datai=32'h88000000, rPC=RESET_PC, fBUSY=0.
  - Reset mid-request abandons the request; a late if_ack after reset is ignored while state=IDLE.
- At most one outstanding request.
- States:
  - IDLE:
    - If count < DEPTH and no br_en: go to REQ, assert if_req, set if_adr=fetch_pc.
    - Request launches the cycle after the decision (registered if_req).
  - REQ:
    - if_req and if_adr stay stable until if_ack.
    - On if_ack without br_en: push {if_dat, if_adr}, fetch_pc += 4 (wraps 32'hFFFFFFFC→0), go to IDLE.
    - On br_en without ack: go to DISCARD.
    - On br_en with same-cycle ack: data dropped, go to IDLE.
  - DISCARD:
    - if_req held until if_ack; data dropped; then go to IDLE.
    - A further br_en here overrides fetch_pc again and stays in DISCARD.
- Space check: a request issues only if count < DEPTH at the issue decision. A pop in the same cycle as the decision does not count toward space, so the FIFO cannot overflow.
- Throughput: one word per 2 cycles minimum (IDLE→REQ→ack).
- Output and pop:
  - Head presented combinationally from FIFO storage.
  - d_en && ins_vld pops the head; d_en on empty is a no-op.
  - Push and pop in the same cycle: count unchanged, ordering preserved.
- br_en (any state):
  - FIFO flushed that cycle; count=0 next cycle; ins_vld=0.
  - fetch_pc={br_adr[31:2],2'b00}.
  - br_en has priority over d_en and over push.
  - rPC shows the target next cycle.
- Pointers are log2(DEPTH)-bit and wrap naturally; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro AEXM_IFETCH_BUSERR_EN.
- Defined:
  - Adds input if_err (1 bit), sampled only with if_ack.
  - On if_ack&&if_err in REQ: the pushed word is replaced by 32'hBA2D0008 (exception vector 0x08 op); PC stored is the faulting if_adr; fetch_pc is not advanced.
  - Fetch halts in IDLE until br_en.
- Undefined:
  - No if_err port.
  - Data pushed unmodified; fetch never halts.

Test Plan:
1. Reset release, memory acks 1 cycle after each req with data=adr^32'hA5A5A5A5, d_en=0 → if_adr sequence 0,4,8,C; FIFO fills to 4, then if_req stays 0; head=32'hA5A5A5A5, rPC=0.
2. Full FIFO, d_en=1 for 1 cycle → head advances to 32'hA5A5A5A1, rPC=4; exactly one new request to 32'h10 issues.
3. br_en with br_adr=32'h00000103 while idle and FIFO holds 3 words → ins_vld=0 next cycle, rPC=32'h100, next if_adr=32'h100.
4. br_en to 32'h200 while request to 32'h8 outstanding, ack 3 cycles later → that data never appears; if_req stays high until ack; next request to 32'h200.
5. Simultaneous br_en (32'h40) and if_ack → data dropped, no DISCARD; next if_adr=32'h40. Simultaneous push and pop with count=2 → count stays 2.
6. AEXM_IFETCH_BUSERR_EN: if_err with ack at 32'h8 → head word 32'hBA2D0008, rPC=8; no further if_req until br_en.
